// File: rtl/lockstep_delay_line.sv
// lockstep_delay_line: buffers leader-core samples and replays each one after a
// run-time programmable delay, so the lockstep comparator sees the leader stream
// aligned with the shadow core.
// Optional feature macro: LOCKSTEP_DELAY_PARITY_EN (per-entry even parity plus par_err).
module lockstep_delay_line #(
    parameter int LENGTH    = 32,
    parameter int DEPTH     = 8,
    parameter int MAX_DELAY = 15,
    parameter int RST_DELAY = 3,
    localparam int DW = $clog2(MAX_DELAY + 1),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              flush,
    input  logic              cfg_we,
    input  logic [DW-1:0]     delay_cfg,
    input  logic              in_valid,
    input  logic [LENGTH-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [LENGTH-1:0] out_data,
    output logic [LW-1:0]     level,
`ifdef LOCKSTEP_DELAY_PARITY_EN
    output logic              par_err,
`endif
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

    state_t                     state_reg, state_next;
    logic [LENGTH-1:0]          data_mem [DEPTH];
    logic [DEPTH-1:0]           valid_reg, valid_next;
    logic [DEPTH-1:0][DW-1:0]   age_reg, age_next;
    logic [AW-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]              level_reg, level_next;
    logic [DW-1:0]              delay_reg, delay_next;
    logic                       overflow_reg, overflow_next;
    logic                       wr_en, pop, drop, head_mature_next;

    // The FSM state already reflects head maturity, so out_valid is a plain register decode.
    assign out_valid = (state_reg == STREAM);
    assign out_data  = out_valid ? data_mem[rd_ptr_reg] : '0;
    assign level     = level_reg;
    assign overflow  = overflow_reg;

    // A write may proceed into a full buffer when the head leaves in the same cycle.
    assign pop   = out_valid && out_ready && !flush;
    assign wr_en = in_valid && !flush && ((level_reg < LW'(DEPTH)) || pop);
    assign drop  = in_valid && !flush && !wr_en;

    // Per-entry next valid flag and age: new entries start at 0, live entries saturate at MAX_DELAY.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic wr_hit, pop_hit;
            assign wr_hit  = wr_en && (wr_ptr_reg == AW'(gi));
            assign pop_hit = pop && (rd_ptr_reg == AW'(gi));
            assign valid_next[gi] = flush   ? 1'b0 :
                                    wr_hit  ? 1'b1 :
                                    pop_hit ? 1'b0 : valid_reg[gi];
            assign age_next[gi]   = wr_hit ? '0 :
                                    (valid_reg[gi] && (age_reg[gi] != MAX_D)) ? age_reg[gi] + DW'(1)
                                                                              : age_reg[gi];
        end
    endgenerate

    // Pointer, level, overflow and delay updates; flush clears everything except the delay.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        overflow_next = overflow_reg;
        delay_next    = delay_reg;
        if (cfg_we && (state_reg == IDLE)) begin
            if ({{(32-DW){1'b0}}, delay_cfg} > 32'(MAX_DELAY))
                delay_next = MAX_D;
            else
                delay_next = delay_cfg;
        end
        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            level_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (wr_en) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)   rd_ptr_next = rd_ptr_reg + AW'(1);
            level_next = level_reg + LW'(wr_en) - LW'(pop);
            if (drop) overflow_next = 1'b1;
        end
        head_mature_next = valid_next[rd_ptr_next] && (age_next[rd_ptr_next] >= delay_next);
    end

    // Next-state logic: the state tracks whether the head will be mature in the coming cycle.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (wr_en) state_next = head_mature_next ? STREAM : WAIT;
                WAIT:    if (head_mature_next) state_next = STREAM;
                STREAM:  if (pop) begin
                             if (level_next == '0)       state_next = IDLE;
                             else if (!head_mature_next) state_next = WAIT;
                         end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Control registers: entry flags, ages, pointers, level, overflow, delay.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_reg    <= '0;
            age_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
            delay_reg    <= DW'(RST_DELAY);
        end else begin
            valid_reg    <= valid_next;
            age_reg      <= age_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            overflow_reg <= overflow_next;
            delay_reg    <= delay_next;
        end
    end

    // Sample storage; contents need no reset because entry valid flags gate their use.
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_ptr_reg] <= in_data;
    end

`ifdef LOCKSTEP_DELAY_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_reg;

    assign par_err = par_err_reg;

    // Even-parity bit captured alongside each sample.
    always_ff @(posedge clk) begin
        if (wr_en) par_mem[wr_ptr_reg] <= ^in_data;
    end

    // Parity is re-checked on the popped head; a mismatch flags for one cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) par_err_reg <= 1'b0;
        else        par_err_reg <= pop && ((^data_mem[rd_ptr_reg]) != par_mem[rd_ptr_reg]);
    end
`endif

endmodule

// File: tb/tb_lockstep_delay_line.sv
// Directed testbench for lockstep_delay_line: latency, streaming, overflow,
// delay programming, flush, asynchronous reset and (optionally) parity.
module tb_lockstep_delay_line;

    localparam int LENGTH = 32;
    localparam int DW     = 4;
    localparam int LW     = 4;

    logic              clk;
    logic              rst_l;
    logic              flush;
    logic              cfg_we;
    logic [DW-1:0]     delay_cfg;
    logic              in_valid;
    logic [LENGTH-1:0] in_data;
    logic              out_ready;
    logic              out_valid;
    logic [LENGTH-1:0] out_data;
    logic [LW-1:0]     level;
    logic              overflow;
`ifdef LOCKSTEP_DELAY_PARITY_EN
    logic              par_err;
`endif

    int checks   = 0;
    int failures = 0;

    lockstep_delay_line #(
        .LENGTH(32), .DEPTH(8), .MAX_DELAY(15), .RST_DELAY(3)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush     (flush),
        .cfg_we    (cfg_we),
        .delay_cfg (delay_cfg),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (level),
`ifdef LOCKSTEP_DELAY_PARITY_EN
        .par_err   (par_err),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        delay_cfg = d;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Send one sample with the consumer ready and measure cycles until it appears.
    task automatic measure_latency(input string tag, input logic [31:0] d, input int exp_lat);
        int cnt;
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check_val({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
        check_val({tag, "_data"}, out_data, d);
        tick();
        check_val({tag, "_level_after"}, 32'(level), 32'd0);
    endtask

    initial begin
        int cnt;
        rst_l = 1'b0; flush = 1'b0; cfg_we = 1'b0; delay_cfg = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        rst_l = 1'b1;
        tick();

        // 1: reset delay 3, one sample at cycle 0 -> out_valid at cycle 4, level 0 at 5
        in_valid = 1'b1; in_data = 32'hA5A5A5A5; out_ready = 1'b1;
        check_val("t1_c0_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check_val($sformatf("t1_c%0d_valid", c), 32'(out_valid), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) check_val("t1_c4_data", out_data, 32'hA5A5A5A5);
            if (c == 1) check_val("t1_c1_level", 32'(level), 32'd1);
            if (c == 5) check_val("t1_c5_level", 32'(level), 32'd0);
            tick();
        end

        // 2: delay 0, 8 back-to-back samples -> outputs 1..8 on cycles 1..8
        set_delay(4'd0);
        out_ready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            in_valid = (c < 8);
            in_data  = 32'(c + 1);
            if (c >= 1 && c <= 8) begin
                check_val($sformatf("t2_c%0d_valid", c), 32'(out_valid), 32'd1);
                check_val($sformatf("t2_c%0d_data", c), out_data, 32'(c));
            end else begin
                check_val($sformatf("t2_c%0d_valid", c), 32'(out_valid), 32'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        check_val("t2_overflow", 32'(overflow), 32'd0);

        // 3: stalled consumer, 9 writes -> full, 9th dropped, then drain in order
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(c + 1);
            tick();
        end
        in_valid = 1'b0;
        check_val("t3_level_full", 32'(level), 32'd8);
        check_val("t3_overflow", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("t3_pop%0d_valid", k), 32'(out_valid), 32'd1);
            check_val($sformatf("t3_pop%0d_data", k), out_data, 32'h100 + 32'(k + 1));
            tick();
        end
        check_val("t3_drained_valid", 32'(out_valid), 32'd0);
        check_val("t3_drained_level", 32'(level), 32'd0);
        check_val("t3_overflow_held", 32'(overflow), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("t3_overflow_flushed", 32'(overflow), 32'd0);

        // 4: cfg_we ignored with level=2, honoured in IDLE
        set_delay(4'd3);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hAAAA0001;
        tick();
        in_data = 32'hAAAA0002;
        tick();
        in_valid = 1'b0;
        check_val("t4_level2", 32'(level), 32'd2);
        cfg_we = 1'b1; delay_cfg = 4'd7;
        tick();
        cfg_we = 1'b0;
        out_ready = 1'b1;
        cnt = 3;
        while (!out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check_val("t4_first_cycle", 32'(cnt), 32'd4);
        check_val("t4_first_data", out_data, 32'hAAAA0001);
        tick();
        check_val("t4_second_valid", 32'(out_valid), 32'd1);
        check_val("t4_second_data", out_data, 32'hAAAA0002);
        tick();
        check_val("t4_level0", 32'(level), 32'd0);
        measure_latency("t4_d3", 32'h00C0FFEE, 4);
        set_delay(4'd7);
        measure_latency("t4_d7", 32'h00000777, 8);
        set_delay(4'd15);
        measure_latency("t4_d15", 32'h0000FFFF, 16);

        // 5: flush while streaming with a same-cycle write
        set_delay(4'd0);
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            in_valid = 1'b1;
            in_data  = 32'h200 + 32'(c);
            tick();
        end
        check_val("t5_pre_valid", 32'(out_valid), 32'd1);
        check_val("t5_pre_overflow", 32'(overflow), 32'd1);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_val("t5_flush_level", 32'(level), 32'd0);
        check_val("t5_flush_valid", 32'(out_valid), 32'd0);
        check_val("t5_flush_overflow", 32'(overflow), 32'd0);
        check_val("t5_flush_data", out_data, 32'd0);
        repeat (4) tick();
        check_val("t5_no_ghost", 32'(out_valid), 32'd0);

        // 5b: asynchronous reset mid-stream clears outputs without a clock edge
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55555555;
        tick();
        in_valid = 1'b0;
        check_val("t5_pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        check_val("t5_arst_valid", 32'(out_valid), 32'd0);
        check_val("t5_arst_data", out_data, 32'd0);
        check_val("t5_arst_level", 32'(level), 32'd0);
        tick();
        rst_l = 1'b1;
        tick();
        measure_latency("t5_rst_delay", 32'h12345678, 4);

`ifdef LOCKSTEP_DELAY_PARITY_EN
        // 6: corrupt one stored bit, expect a one-cycle par_err after its pop
        begin
            logic [LENGTH-1:0] tmp;
            set_delay(4'd0);
            check_val("t6_par_idle", 32'(par_err), 32'd0);
            out_ready = 1'b0;
            in_valid = 1'b1; in_data = 32'h0F0F0F0F;
            tick();
            in_valid = 1'b0;
            tmp = dut.data_mem[dut.rd_ptr_reg];
            tmp[0] = ~tmp[0];
            dut.data_mem[dut.rd_ptr_reg] = tmp;
            #1;
            check_val("t6_bad_data", out_data, 32'h0F0F0F0E);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_val("t6_par_err_pulse", 32'(par_err), 32'd1);
            tick();
            check_val("t6_par_err_clear", 32'(par_err), 32'd0);
            out_ready = 1'b1;
            in_valid = 1'b1; in_data = 32'h0F0F0F0F;
            tick();
            in_valid = 1'b0;
            tick();
            check_val("t6_clean_par_err", 32'(par_err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
